pwm_breathe_bank: RTL and testbench

//   Multi-channel LED PWM engine; parametrised successor to the single-channel 6-bit breathing blinker.

---
 rtl/pwm_breathe_bank.sv | 145 ++++++++++++++
 tb/tb_pwm_breathe_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_breathe_bank.sv
// Multi-channel LED PWM engine: shared counter and step prescaler, per-channel static or breathing level.
// Define PWM_GAMMA_EN to compare against a squared (perceptual) level instead of the linear one.
module pwm_breathe_bank #(
    parameter int CHANNELS = 8,
    parameter int PWM_BITS = 6,
    parameter int STEP_DIV = 4096
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              enable,
    input  logic [CHANNELS-1:0]                               mode,
    input  logic                                              duty_wr,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] duty_sel,
    input  logic [PWM_BITS-1:0]                               duty_data,
    output logic [CHANNELS-1:0]                               pwm_out,
    output logic [CHANNELS*PWM_BITS-1:0]                      level_out,
    output logic                                              period_strb
);

    localparam int P     = 1 << PWM_BITS;
    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] ZERO     = '0;
    localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);
    localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);

    // Staggered start so breathing channels are spread across the ramp.
    function automatic logic [PWM_BITS-1:0] init_level(input int i);
        int v;
        v = (i * P) / CHANNELS;
        return v[PWM_BITS-1:0];
    endfunction

`ifdef PWM_GAMMA_EN
    function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] s);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, s} * {{PWM_BITS{1'b0}}, s};
        return sq[2*PWM_BITS-1:PWM_BITS];
    endfunction
`endif

    logic [PWM_BITS-1:0] cnt;
    logic [PRE_W-1:0]    presc;
    logic                wrap;
    logic                step_tick;

    assign wrap      = enable && (cnt == MAX);
    assign step_tick = wrap && (presc == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            presc       <= '0;
            period_strb <= 1'b0;
        end else begin
            period_strb <= wrap;
            if (enable) begin
                cnt <= cnt + ONE;
            end
            if (wrap) begin
                presc <= step_tick ? '0 : presc + PRE_ONE;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [PWM_BITS-1:0] INIT = init_level(i);

        logic [PWM_BITS-1:0] level_q;
        logic [PWM_BITS-1:0] cmp;
        logic                down_q;
        logic                pwm_q;
        logic                sel_hit;

        assign sel_hit = duty_wr && (32'(duty_sel) == i);

        // A write always beats a breathe step; leaving static mode re-arms the ramp upwards.
        always_ff @(posedge clk) begin
            if (rst) begin
                level_q <= INIT;
                down_q  <= 1'b0;
            end else begin
                if (!mode[i]) begin
                    down_q <= 1'b0;
                end
                if (sel_hit) begin
                    level_q <= duty_data;
                end else if (mode[i] && step_tick) begin
                    if (!down_q) begin
                        if (level_q == MAX) begin
                            down_q  <= 1'b1;
                            level_q <= level_q - ONE;
                        end else begin
                            level_q <= level_q + ONE;
                        end
                    end else begin
                        if (level_q == ZERO) begin
                            down_q  <= 1'b0;
                            level_q <= ONE;
                        end else begin
                            level_q <= level_q - ONE;
                        end
                    end
                end
            end
        end

`ifdef PWM_GAMMA_EN
        // The curved compare value is latched at the wrap, so it doubles as the shadow.
        always_ff @(posedge clk) begin
            if (rst) begin
                cmp <= gamma(INIT);
            end else if (wrap) begin
                cmp <= gamma(level_q);
            end
        end
`else
        logic [PWM_BITS-1:0] shadow_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_q <= INIT;
            end else if (wrap) begin
                shadow_q <= level_q;
            end
        end

        assign cmp = shadow_q;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                pwm_q <= 1'b0;
            end else begin
                pwm_q <= enable && (cnt < cmp);
            end
        end

        assign pwm_out[i]                          = pwm_q;
        assign level_out[i*PWM_BITS +: PWM_BITS] = level_q;
    end

endmodule

// File: tb/tb_pwm_breathe_bank.sv
// Randomised self-checking bench for pwm_breathe_bank against a cycle-level integer model.
module tb_pwm_breathe_bank;

    localparam int CH       = 4;
    localparam int BITS     = 4;
    localparam int STEP_DIV = 2;
    localparam int P        = 1 << BITS;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [CH-1:0]   mode;
    logic            duty_wr;
    logic [1:0]      duty_sel;
    logic [BITS-1:0] duty_data;
    logic [CH-1:0]   pwm_out;
    logic [CH*BITS-1:0] level_out;
    logic            period_strb;

    logic            wr6;
    logic [2:0]      sel6;
    logic [BITS-1:0] data6;
    logic [5:0]      pwm_out6;
    logic [6*BITS-1:0] level_out6;
    logic            period_strb6;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_breathe_bank #(.CHANNELS(CH), .PWM_BITS(BITS), .STEP_DIV(STEP_DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_data(duty_data),
        .pwm_out(pwm_out), .level_out(level_out), .period_strb(period_strb)
    );

    pwm_breathe_bank #(.CHANNELS(6), .PWM_BITS(BITS), .STEP_DIV(STEP_DIV)) dut6 (
        .clk(clk), .rst(rst), .enable(enable), .mode(6'b0),
        .duty_wr(wr6), .duty_sel(sel6), .duty_data(data6),
        .pwm_out(pwm_out6), .level_out(level_out6), .period_strb(period_strb6)
    );

    // Reference model: integer counters and levels advanced once per rising edge.
    int   m_cnt, m_presc;
    int   m_level[CH];
    int   m_shadow[CH];
    bit   m_rise[CH];
    logic [CH-1:0]      exp_pwm;
    logic [CH*BITS-1:0] exp_level;
    logic               exp_strb;
    bit   model_valid = 1'b0;

    function automatic int cmp_of(input int s);
`ifdef PWM_GAMMA_EN
        return (s * s) / P;
`else
        return s;
`endif
    endfunction

    always @(posedge clk) begin
        bit wrap, tick;
        if (rst) begin
            m_cnt = 0;
            m_presc = 0;
            for (int i = 0; i < CH; i++) begin
                m_level[i]  = (i * P) / CH;
                m_shadow[i] = m_level[i];
                m_rise[i]   = 1'b1;
            end
            exp_pwm     = '0;
            exp_strb    = 1'b0;
            model_valid = 1'b1;
        end else begin
            wrap = enable && (m_cnt == P - 1);
            tick = wrap && (m_presc == STEP_DIV - 1);
            for (int i = 0; i < CH; i++) begin
                exp_pwm[i] = enable && (m_cnt < cmp_of(m_shadow[i]));
            end
            exp_strb = wrap;
            for (int i = 0; i < CH; i++) begin
                if (wrap) m_shadow[i] = m_level[i];
                if (!mode[i]) m_rise[i] = 1'b1;
                if (duty_wr && (int'(duty_sel) == i)) begin
                    m_level[i] = int'(duty_data);
                end else if (mode[i] && tick) begin
                    if (m_rise[i] && m_level[i] == P - 1) m_rise[i] = 1'b0;
                    else if (!m_rise[i] && m_level[i] == 0) m_rise[i] = 1'b1;
                    m_level[i] += m_rise[i] ? 1 : -1;
                end
            end
            if (enable) m_cnt = (m_cnt + 1) % P;
            if (wrap) m_presc = tick ? 0 : m_presc + 1;
        end
        for (int i = 0; i < CH; i++) begin
            exp_level[i*BITS +: BITS] = BITS'(m_level[i]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("pwm_out", 32'(pwm_out), 32'(exp_pwm));
            checkOutput("level_out", 32'(level_out), 32'(exp_level));
            checkOutput("period_strb", 32'(period_strb), 32'(exp_strb));
            checkOutput("period_strb_6ch", 32'(period_strb6), 32'(exp_strb));
        end
    end

    // Caller sits on a falling edge; the strobe is held for exactly one clock.
    task automatic applyStimulus(input bit wr, input int sel, input int data);
        duty_wr   = wr;
        duty_sel  = 2'(sel);
        duty_data = BITS'(data);
        @(negedge clk);
        duty_wr = 1'b0;
    endtask

    task automatic wait_strb(output int n);
        bit seen = 1'b0;
        n = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (period_strb) seen = 1'b1;
        end
        checkOutput("strb_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_level(input int ch, input int req, input string name);
        int  prev, cur;
        bit  seen = 1'b0;
        prev = int'(level_out[ch*BITS +: BITS]);
        cur  = prev;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            cur = int'(level_out[ch*BITS +: BITS]);
            if (cur != prev) seen = 1'b1;
        end
        checkOutput({name, "_seen"}, 32'(seen), 32'd1);
        checkOutput(name, 32'(cur), 32'(req));
    endtask

    task automatic wait_cnt(input int v);
        for (int k = 0; k < 64 && m_cnt != v; k++) @(negedge clk);
        checkOutput("cnt_reached", 32'(m_cnt), 32'(v));
    endtask

    task automatic measure_duty(input int lvl, input int req, input string name);
        int n, high;
        applyStimulus(1'b1, 1, lvl);
        wait_strb(n);
        wait_strb(n);
        high = 0;
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            high += int'(pwm_out[1]);
        end
        checkOutput(name, 32'(high), 32'(req));
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; mode = '0;
        duty_wr = 1'b0; duty_sel = '0; duty_data = '0;
        wr6 = 1'b0; sel6 = '0; data6 = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_levels", 32'(level_out), 32'hC840);
        checkOutput("reset_pwm", 32'(pwm_out), 32'h0);
        checkOutput("reset_levels_6ch", 32'(level_out6), 32'hDA8520);
        rst = 1'b0;
        wait_strb(n);
        checkOutput("first_strb_delay", 32'(n), 32'd16);

        wr6 = 1'b1; sel6 = 3'd5; data6 = 4'd9;
        @(negedge clk);
        wr6 = 1'b0;
        checkOutput("sel5_written_6ch", 32'(level_out6), 32'h9A8520);
        wr6 = 1'b1; sel6 = 3'd7; data6 = 4'd3;
        @(negedge clk);
        wr6 = 1'b0;
        checkOutput("sel7_ignored_6ch", 32'(level_out6), 32'h9A8520);

`ifdef PWM_GAMMA_EN
        measure_duty(8, 4, "gamma_duty_8");
        measure_duty(15, 14, "gamma_duty_15");
`else
        measure_duty(5, 5, "static_duty_5");
        measure_duty(15, 15, "static_duty_15");
`endif
        measure_duty(0, 0, "static_duty_0");

        mode = 4'b0001;
        applyStimulus(1'b1, 0, 14);
        wait_level(0, 15, "ramp_up_15");
        wait_level(0, 14, "turn_down_14");
        wait_level(0, 13, "ramp_down_13");
        applyStimulus(1'b1, 0, 1);
        wait_level(0, 0, "ramp_down_0");
        wait_level(0, 1, "turn_up_1");
        wait_level(0, 2, "ramp_up_2");

        mode = 4'b0100;
        applyStimulus(1'b1, 2, 10);
        for (int k = 0; k < 64 && !(m_cnt == P - 1 && m_presc == STEP_DIV - 1); k++) @(negedge clk);
        applyStimulus(1'b1, 2, 3);
        checkOutput("collision_write_wins", 32'(level_out[2*BITS +: BITS]), 32'd3);

        mode = 4'b0000;
        wait_cnt(7);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("disable_pwm_low", 32'(pwm_out), 32'h0);
        checkOutput("disable_pwm_low_6ch", 32'(pwm_out6), 32'h0);
        applyStimulus(1'b1, 3, 6);
        checkOutput("write_while_disabled", 32'(level_out[3*BITS +: BITS]), 32'd6);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_strb(n);
        checkOutput("resume_from_cnt7", 32'(n), 32'd9);

        wait_cnt(9);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_levels", 32'(level_out), 32'hC840);
        checkOutput("midrun_reset_pwm", 32'(pwm_out), 32'h0);
        checkOutput("midrun_reset_levels_6ch", 32'(level_out6), 32'hDA8520);
        rst = 1'b0;
        wait_strb(n);
        checkOutput("strb_after_midrun_reset", 32'(n), 32'd16);

        for (int c = 0; c < 2500; c++) begin
            duty_wr   = ($urandom % 6) == 0;
            duty_sel  = 2'($urandom % CH);
            duty_data = BITS'($urandom % P);
            if (($urandom % 40) == 0) mode = mode ^ CH'(1 << ($urandom % CH));
            if (enable && ($urandom % 150) == 0) enable = 1'b0;
            else if (!enable && ($urandom % 6) == 0) enable = 1'b1;
            @(negedge clk);
        end
        duty_wr = 1'b0;
        enable  = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
